// File: rtl/flick_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button, then
// emits one fixed-width flick pulse per accepted press, followed by a lockout.
module flick_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       enable,
  output logic       flick,
  output logic       btn_level,
  output logic [7:0] press_count,
  output logic       busy
);

  localparam logic [7:0] DEB_LIMIT    = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] LOCKOUT_LAST = 8'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;
  logic [7:0]             db_cnt_reg, db_cnt_next;
  logic                   level_reg, level_next;
  logic                   level_d_reg;
  logic                   rise;
  state_t                 state_reg, state_next;
  logic [7:0]             timer_reg, timer_next;
  logic                   accept;
  logic                   flick_reg;
  logic                   busy_reg;
  logic [7:0]             count_reg;

  assign sync = sync_reg[SYNC_STAGES-1];
  assign rise = level_reg & ~level_d_reg;

  // Debounce: any cycle that agrees with the current level restarts the count.
  always_comb begin
    db_cnt_next = db_cnt_reg;
    level_next  = level_reg;
    if (sync == level_reg) begin
      db_cnt_next = 8'd0;
    end else if (db_cnt_reg + 8'd1 == DEB_LIMIT) begin
      level_next  = ~level_reg;
      db_cnt_next = 8'd0;
    end else begin
      db_cnt_next = db_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise && enable) begin
          state_next = PULSE;
          timer_next = 8'd0;
          accept     = 1'b1;
        end
      end
      PULSE: begin
        if (timer_reg == PULSE_LAST) begin
          timer_next = 8'd0;
          if (LOCKOUT_CYCLES == 0) begin
            state_next = level_reg ? WAIT_RELEASE : IDLE;
          end else begin
            state_next = LOCKOUT;
          end
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      LOCKOUT: begin
        if (timer_reg == LOCKOUT_LAST) begin
          timer_next = 8'd0;
          state_next = level_reg ? WAIT_RELEASE : IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      WAIT_RELEASE: begin
        if (!level_reg) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg    <= '0;
      db_cnt_reg  <= 8'd0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      state_reg   <= IDLE;
      timer_reg   <= 8'd0;
      flick_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      count_reg   <= 8'd0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
      db_cnt_reg  <= db_cnt_next;
      level_reg   <= level_next;
      level_d_reg <= level_reg;
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      flick_reg   <= (state_next == PULSE);
      busy_reg    <= (state_next != IDLE);
      if (accept) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign flick       = flick_reg;
  assign btn_level   = level_reg;
  assign press_count = count_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_flick_conditioner.sv
// Scoreboard bench: stimulus queues expected flick arrivals, a monitor
// compares each flick rising edge against the queue head.
module tb_flick_conditioner;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       btn, btn2;
  logic       enable;
  logic       flick, flick2;
  logic       btn_level, btn_level2;
  logic [7:0] press_count, press_count2;
  logic       busy, busy2;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int exp_cyc;
    int exp_cnt;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flick_conditioner dut (
    .clock(clk), .reset(rst), .btn_raw(btn), .enable(enable),
    .flick(flick), .btn_level(btn_level), .press_count(press_count), .busy(busy)
  );

  flick_conditioner #(.PULSE_CYCLES(4)) dut2 (
    .clock(clk), .reset(rst2), .btn_raw(btn2), .enable(enable),
    .flick(flick2), .btn_level(btn_level2), .press_count(press_count2), .busy(busy2)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic drive(input logic v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  logic flick_prev = 1'b0;
  int   width      = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (flick && !flick_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flick: got flick at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("flick cycle=%0d press_count=%0d (exp cycle=%0d count=%0d)",
                   cyc, press_count, e.exp_cyc, e.exp_cnt);
          check("flick_cycle", cyc, e.exp_cyc);
          check("press_count", int'(press_count), e.exp_cnt);
        end
      end
      if (!flick && flick_prev) check("pulse_width", width, 1);
      while (sb_q.size() > 0 && cyc > sb_q[0].exp_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_flick: got none by cycle %0d expected at %0d", cyc, sb_q[0].exp_cyc);
        void'(sb_q.pop_front());
      end
    end
    width      = flick ? width + 1 : 0;
    flick_prev = flick;
  end

  initial begin
    int c0;
    int busy_n;
    int seen;
    logic bounce_pat [8];

    rst = 1'b1; rst2 = 1'b1; btn = 1'b0; btn2 = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flick", flick, 0);
    check("rst_level", btn_level, 0);
    check("rst_count", int'(press_count), 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);

    // Bounce shorter than the debounce window
    bounce_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      btn = bounce_pat[i];
      @(negedge clk);
      if (btn_level || busy) seen++;
    end
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (btn_level || busy) seen++;
    end
    check("bounce_level_busy", seen, 0);
    check("bounce_count", int'(press_count), 0);

    // Clean press held 20 cycles
    c0 = cyc;
    sb_q.push_back('{c0 + 7, 1});
    btn = 1'b1;
    busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (i == 5) check("level_before_window", btn_level, 0);
      if (i == 6) check("level_after_window", btn_level, 1);
    end
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    check("busy_cycles", busy_n, 20);
    check("level_released", btn_level, 0);

    // Second press inside lockout
    c0 = cyc;
    sb_q.push_back('{c0 + 7, 2});
    drive(1'b1, 6);
    drive(1'b0, 3);
    drive(1'b1, 6);
    drive(1'b0, 30);
    check("double_count", int'(press_count), 2);

    // Press while disabled, enable raised while still held
    enable = 1'b0;
    drive(1'b1, 10);
    enable = 1'b1;
    drive(1'b1, 10);
    drive(1'b0, 20);
    check("gated_count", int'(press_count), 2);
    c0 = cyc;
    sb_q.push_back('{c0 + 7, 3});
    drive(1'b1, 6);
    drive(1'b0, 20);

    // Run the counter up to the wrap
    for (int k = 4; k <= 256; k++) begin
      c0 = cyc;
      sb_q.push_back('{c0 + 7, k % 256});
      drive(1'b1, 6);
      drive(1'b0, 14);
    end
    drive(1'b0, 10);
    check("wrap_count", int'(press_count), 0);

    // Button held across a 3-cycle reset
    c0 = cyc;
    rst = 1'b1;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_rst_flick", flick, 0);
    check("hold_rst_level", btn_level, 0);
    check("hold_rst_count", int'(press_count), 0);
    check("hold_rst_busy", busy, 0);
    rst = 1'b0;
    sb_q.push_back('{c0 + 10, 1});
    drive(1'b1, 14);
    drive(1'b0, 25);

    // Reset in the middle of a 4-cycle pulse
    c0 = cyc;
    btn2 = 1'b1;
    repeat (6) @(negedge clk);
    check("p4_before", flick2, 0);
    @(negedge clk);
    check("p4_rise", flick2, 1);
    @(negedge clk);
    check("p4_held", flick2, 1);
    check("p4_count", int'(press_count2), 1);
    rst2 = 1'b1;
    btn2 = 1'b0;
    @(negedge clk);
    check("p4_rst_flick", flick2, 0);
    check("p4_rst_busy", busy2, 0);
    check("p4_rst_level", btn_level2, 0);
    check("p4_rst_count", int'(press_count2), 0);
    rst2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (flick2 || busy2) seen++;
    end
    check("p4_not_resumed", seen, 0);

    repeat (10) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
